// File: rtl/foreach_walk_pkg.sv
// Shared types and helpers for the nested-index walk controller.
package foreach_walk_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } state_e;

    // Accumulation mode: plain sum or shift-then-add.
    typedef enum logic {
        ModeSum      = 1'b0,
        ModeShiftAdd = 1'b1
    } mode_e;

    // Index/address width; a one-entry range still needs a 1-bit signal.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/foreach_idx_step.sv
// Advances (i, j, k) by one element: k innermost, then j (either direction), then i.
module foreach_idx_step
    import foreach_walk_pkg::*;
#(
    parameter int unsigned D0 = 2,
    parameter int unsigned D1 = 3,
    parameter int unsigned D2 = 4,
    localparam int unsigned IW = clog2_min1(D0),
    localparam int unsigned JW = clog2_min1(D1),
    localparam int unsigned KW = clog2_min1(D2)
) (
    input  logic [IW-1:0] i_i,
    input  logic [JW-1:0] j_i,
    input  logic [KW-1:0] k_i,
    input  logic          j_desc_i,
    output logic [IW-1:0] i_o,
    output logic [JW-1:0] j_o,
    output logic [KW-1:0] k_o,
    output logic          last_o
);

    localparam logic [IW-1:0] ILast = IW'(D0 - 1);
    localparam logic [JW-1:0] JTop  = JW'(D1 - 1);
    localparam logic [KW-1:0] KLast = KW'(D2 - 1);

    logic k_end;
    logic j_end;

    // Next index triple and end-of-walk flag for the current element.
    always_comb begin
        k_end  = (k_i == KLast);
        j_end  = j_desc_i ? (j_i == '0) : (j_i == JTop);
        i_o    = i_i;
        j_o    = j_i;
        k_o    = k_i;
        last_o = k_end && j_end && (i_i == ILast);
        if (!k_end) begin
            k_o = k_i + KW'(1);
        end else begin
            k_o = '0;
            if (!j_end) begin
                j_o = j_desc_i ? (j_i - JW'(1)) : (j_i + JW'(1));
            end else begin
                j_o = j_desc_i ? JTop : '0;
                i_o = (i_i == ILast) ? '0 : (i_i + IW'(1));
            end
        end
    end

endmodule

// File: rtl/foreach_walk_ctrl.sv
// Walks a D0 x D1 x D2 element space, reading each element and accumulating it.
module foreach_walk_ctrl
    import foreach_walk_pkg::*;
#(
    parameter int unsigned D0    = 2,
    parameter int unsigned D1    = 3,
    parameter int unsigned D2    = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned ACC_W = 32,
    localparam int unsigned IW = clog2_min1(D0),
    localparam int unsigned JW = clog2_min1(D1),
    localparam int unsigned KW = clog2_min1(D2),
    localparam int unsigned N  = D0 * D1 * D2,
    localparam int unsigned AW = clog2_min1(N),
    localparam int unsigned CW = clog2_min1(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             j_desc,
    input  logic             mode,
    input  logic             brk_en,
    input  logic [IW-1:0]    brk_i,
    input  logic [JW-1:0]    brk_j,
    input  logic [KW-1:0]    brk_k,
    output logic             rd_req,
    output logic [AW-1:0]    rd_addr,
    input  logic             rd_valid,
    input  logic [DW-1:0]    rd_data,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] result,
    output logic [CW-1:0]    count
);

    state_e            state_q, state_d;
    logic [IW-1:0]     i_q, i_d;
    logic [JW-1:0]     j_q, j_d;
    logic [KW-1:0]     k_q, k_d;
    logic              jd_q, jd_d;
    mode_e             mode_q, mode_d;
    logic              be_q, be_d;
    logic [IW-1:0]     bi_q, bi_d;
    logic [JW-1:0]     bj_q, bj_d;
    logic [KW-1:0]     bk_q, bk_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]  res_q, res_d;

    logic [IW-1:0]     i_nx;
    logic [JW-1:0]     j_nx;
    logic [KW-1:0]     k_nx;
    logic              last;
    logic              hit;
    logic [ACC_W-1:0]  data_ext;
    logic [ACC_W-1:0]  acc_nx;
    int unsigned       addr_full;

    foreach_idx_step #(
        .D0 (D0),
        .D1 (D1),
        .D2 (D2)
    ) u_idx_step (
        .i_i      (i_q),
        .j_i      (j_q),
        .k_i      (k_q),
        .j_desc_i (jd_q),
        .i_o      (i_nx),
        .j_o      (j_nx),
        .k_o      (k_nx),
        .last_o   (last)
    );

    // Flat address, element data widening and break match for the current element.
    always_comb begin
        addr_full = 32'(i_q) * (D1 * D2) + 32'(j_q) * D2 + 32'(k_q);
        rd_addr   = AW'(addr_full);
        data_ext  = ACC_W'(rd_data);
        acc_nx    = (mode_q == ModeShiftAdd) ? ((acc_q << 1) + data_ext) : (acc_q + data_ext);
        // An out-of-range break index never equals a live index, so it is inert.
        hit       = be_q && (i_q == bi_q) && (j_q == bj_q) && (k_q == bk_q);
    end

    // Next-state logic: config latch on start, accumulate on each accepted element.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        jd_d    = jd_q;
        mode_d  = mode_q;
        be_d    = be_q;
        bi_d    = bi_q;
        bj_d    = bj_q;
        bk_d    = bk_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    jd_d    = j_desc;
                    mode_d  = mode_e'(mode);
                    be_d    = brk_en;
                    bi_d    = brk_i;
                    bj_d    = brk_j;
                    bk_d    = brk_k;
                    acc_d   = '0;
                    cnt_d   = '0;
                    i_d     = '0;
                    k_d     = '0;
                    j_d     = j_desc ? JW'(D1 - 1) : '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                state_d = StWait;
            end
            StWait: begin
                if (rd_valid) begin
                    acc_d = acc_nx;
                    cnt_d = cnt_q + CW'(1);
                    if (last || hit) begin
                        // Result is loaded as DONE is entered so it is valid with the pulse.
                        res_d   = acc_nx;
                        state_d = StDone;
                    end else begin
                        i_d     = i_nx;
                        j_d     = j_nx;
                        k_d     = k_nx;
                        state_d = StReq;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any walk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            jd_q    <= 1'b0;
            mode_q  <= ModeSum;
            be_q    <= 1'b0;
            bi_q    <= '0;
            bj_q    <= '0;
            bk_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            jd_q    <= jd_d;
            mode_q  <= mode_d;
            be_q    <= be_d;
            bi_q    <= bi_d;
            bj_q    <= bj_d;
            bk_q    <= bk_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    // Status outputs decoded from the state register.
    always_comb begin
        rd_req = (state_q == StReq);
        busy   = (state_q != StIdle);
        done   = (state_q == StDone);
        result = res_q;
        count  = cnt_q;
    end

endmodule

// File: tb/tb_foreach_walk_ctrl.sv
// Self-checking bench: default-size instance A and a 3x4x1 instance B, with a loop-based model.
module tb_foreach_walk_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Shared configuration inputs.
    logic       jd, md, be;
    logic [1:0] bi, bj, bk;

    // Instance A (2x3x4).
    logic        a_start, a_rd_req, a_rd_valid, a_busy, a_done;
    logic [4:0]  a_rd_addr, a_count;
    logic [7:0]  a_rd_data;
    logic [31:0] a_result;

    // Instance B (3x4x1).
    logic        b_start, b_rd_req, b_rd_valid, b_busy, b_done;
    logic [3:0]  b_rd_addr, b_count;
    logic [7:0]  b_rd_data;
    logic [31:0] b_result;

    logic [7:0] mem [24];
    int         dly;
    int         a_done_cnt, b_done_cnt;
    int         a_addrs[$];
    int         b_addrs[$];
    int         exp_addrs[$];
    logic [31:0] exp_res;
    int         exp_cnt;
    int         g_base;
    int         n_vec, n_bad;

    foreach_walk_ctrl u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .start    (a_start),
        .j_desc   (jd),
        .mode     (md),
        .brk_en   (be),
        .brk_i    (bi[0:0]),
        .brk_j    (bj),
        .brk_k    (bk),
        .rd_req   (a_rd_req),
        .rd_addr  (a_rd_addr),
        .rd_valid (a_rd_valid),
        .rd_data  (a_rd_data),
        .busy     (a_busy),
        .done     (a_done),
        .result   (a_result),
        .count    (a_count)
    );

    foreach_walk_ctrl #(
        .D0 (3),
        .D1 (4),
        .D2 (1)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (b_start),
        .j_desc   (jd),
        .mode     (md),
        .brk_en   (be),
        .brk_i    (bi),
        .brk_j    (bj),
        .brk_k    (bk[0:0]),
        .rd_req   (b_rd_req),
        .rd_addr  (b_rd_addr),
        .rd_valid (b_rd_valid),
        .rd_data  (b_rd_data),
        .busy     (b_busy),
        .done     (b_done),
        .result   (b_result),
        .count    (b_count)
    );

    // Memory responders: log each request address, answer after dly cycles.
    initial begin : resp_a
        int adr;
        a_rd_valid = 1'b0;
        a_rd_data  = '0;
        forever begin
            @(negedge clk);
            if (a_rd_req) begin
                adr = int'(a_rd_addr);
                a_addrs.push_back(adr);
                repeat (dly) @(negedge clk);
                a_rd_valid = 1'b1;
                a_rd_data  = mem[adr];
                @(posedge clk);
                #1;
                a_rd_valid = 1'b0;
                a_rd_data  = 8'($urandom);
            end
        end
    end

    initial begin : resp_b
        int adr;
        b_rd_valid = 1'b0;
        b_rd_data  = '0;
        forever begin
            @(negedge clk);
            if (b_rd_req) begin
                adr = int'(b_rd_addr);
                b_addrs.push_back(adr);
                repeat (dly) @(negedge clk);
                b_rd_valid = 1'b1;
                b_rd_data  = mem[adr];
                @(posedge clk);
                #1;
                b_rd_valid = 1'b0;
                b_rd_data  = 8'($urandom);
            end
        end
    end

    // Done pulse counters.
    initial begin : mon_done
        a_done_cnt = 0;
        b_done_cnt = 0;
        forever begin
            @(negedge clk);
            if (a_done === 1'b1) a_done_cnt = a_done_cnt + 1;
            if (b_done === 1'b1) b_done_cnt = b_done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: visit elements in i, j, k loop order and fold them per mode.
    task automatic model(input int d0, input int d1, input int d2, input bit jdv, input bit mdv,
                         input bit bev, input int bi_v, input int bj_v, input int bk_v);
        logic [31:0] acc;
        bit          stop;
        exp_addrs.delete();
        acc     = '0;
        exp_cnt = 0;
        stop    = 1'b0;
        for (int i = 0; i < d0; i++) begin
            for (int jj = 0; jj < d1; jj++) begin
                for (int k = 0; k < d2; k++) begin
                    int j;
                    int a;
                    j = jdv ? (d1 - 1 - jj) : jj;
                    a = i * d1 * d2 + j * d2 + k;
                    if (!stop) begin
                        exp_addrs.push_back(a);
                        acc = mdv ? ((acc << 1) + 32'(mem[a])) : (acc + 32'(mem[a]));
                        exp_cnt++;
                        if (bev && i == bi_v && j == bj_v && k == bk_v) stop = 1'b1;
                    end
                end
            end
        end
        exp_res = acc;
    endtask

    task automatic set_start(input bit which, input logic v);
        if (which) b_start = v;
        else       a_start = v;
    endtask

    // One complete walk on instance A (which=0) or B (which=1), checked against the model.
    task automatic walk(input bit which, input bit jd_v, input bit md_v, input bit be_v,
                        input logic [1:0] bi_v, input logic [1:0] bj_v, input logic [1:0] bk_v,
                        input int dly_v, input bit poke, input string tag);
        int base_done, cyc, got_n, lim, got_a, now_done;
        if (which) model(3, 4, 1, jd_v, md_v, be_v, int'(bi_v), int'(bj_v), int'(bk_v));
        else       model(2, 3, 4, jd_v, md_v, be_v, int'(bi_v), int'(bj_v), int'(bk_v));
        dly = dly_v;
        jd = jd_v; md = md_v; be = be_v; bi = bi_v; bj = bj_v; bk = bk_v;
        base_done = which ? b_done_cnt : a_done_cnt;
        g_base    = which ? b_addrs.size() : a_addrs.size();
        @(negedge clk);
        set_start(which, 1'b1);
        @(negedge clk);
        set_start(which, 1'b0);
        if (poke) begin
            jd = ~jd_v; md = ~md_v; be = ~be_v; bi = ~bi_v; bj = ~bj_v; bk = ~bk_v;
        end
        cyc = 0;
        now_done = base_done;
        while (now_done == base_done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 2) set_start(which, 1'b1);
            if (poke && cyc == 3) set_start(which, 1'b0);
            now_done = which ? b_done_cnt : a_done_cnt;
        end
        set_start(which, 1'b0);
        check({tag, "_finish"}, 64'(cyc < 4000), 64'd1);
        repeat (3) @(negedge clk);
        now_done = which ? b_done_cnt : a_done_cnt;
        check({tag, "_done_pulses"}, 64'(now_done - base_done), 64'd1);
        check({tag, "_busy"}, which ? 64'(b_busy) : 64'(a_busy), 64'd0);
        check({tag, "_result"}, which ? 64'(b_result) : 64'(a_result), 64'(exp_res));
        check({tag, "_count"}, which ? 64'(b_count) : 64'(a_count), 64'(exp_cnt));
        got_n = (which ? b_addrs.size() : a_addrs.size()) - g_base;
        check({tag, "_nreq"}, 64'(got_n), 64'(exp_addrs.size()));
        lim = (got_n < exp_addrs.size()) ? got_n : exp_addrs.size();
        for (int n = 0; n < lim; n++) begin
            got_a = which ? b_addrs[g_base + n] : a_addrs[g_base + n];
            check($sformatf("%s_addr%0d", tag, n), 64'(got_a), 64'(exp_addrs[n]));
        end
    endtask

    initial begin : main
        int cyc;
        int last_a;
        bit w, jr, mr, br;
        logic [1:0] ri, rj, rk;
        int rd;
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        a_start = 1'b0; b_start = 1'b0;
        jd = 1'b0; md = 1'b0; be = 1'b0; bi = '0; bj = '0; bk = '0;
        dly = 1;
        for (int a = 0; a < 24; a++) mem[a] = '0;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_a_busy", 64'(a_busy), 64'd0);
        check("rst_a_done", 64'(a_done), 64'd0);
        check("rst_a_req", 64'(a_rd_req), 64'd0);
        check("rst_a_addr", 64'(a_rd_addr), 64'd0);
        check("rst_a_result", 64'(a_result), 64'd0);
        check("rst_a_count", 64'(a_count), 64'd0);
        check("rst_b_busy", 64'(b_busy), 64'd0);
        check("rst_b_result", 64'(b_result), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single one at (1,2,3), everything else zero.
        mem[23] = 8'd1;
        walk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1, 1'b0, "single_one");
        check("single_one_lit_result", 64'(a_result), 64'd1);
        check("single_one_lit_count", 64'(a_count), 64'd24);

        // Descending j order.
        for (int a = 0; a < 24; a++) mem[a] = 8'($urandom);
        walk(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1, 1'b0, "jdesc");
        if (a_addrs.size() >= g_base + 24) begin
            check("jdesc_lit0", 64'(a_addrs[g_base]), 64'd8);
            check("jdesc_lit4", 64'(a_addrs[g_base + 4]), 64'd4);
            check("jdesc_lit12", 64'(a_addrs[g_base + 12]), 64'd20);
            check("jdesc_lit23", 64'(a_addrs[g_base + 23]), 64'd15);
        end

        // Slow responder with start pulsed mid-walk and config scrambled.
        for (int a = 0; a < 24; a++) mem[a] = 8'd1;
        walk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 5, 1'b1, "slow_poke");
        check("slow_poke_lit_count", 64'(a_count), 64'd24);

        // Reset while waiting for read data mid-walk.
        jd = 1'b0; md = 1'b0; be = 1'b0;
        dly = 5;
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        cyc = 0;
        while (!(a_count >= 5'd3 && a_busy && !a_rd_req) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("midrst_reach_wait", 64'(cyc < 500), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(a_busy), 64'd0);
        check("midrst_req", 64'(a_rd_req), 64'd0);
        check("midrst_count", 64'(a_count), 64'd0);
        check("midrst_result", 64'(a_result), 64'd0);
        check("midrst_done", 64'(a_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        for (int a = 0; a < 24; a++) mem[a] = 8'($urandom);
        walk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2, 1'b0, "after_rst");

        // 3x4x1, shift-add, all ones.
        for (int a = 0; a < 24; a++) mem[a] = 8'd1;
        walk(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1, 1'b0, "b_full");
        check("b_full_lit_result", 64'(b_result), 64'd4095);
        check("b_full_lit_count", 64'(b_count), 64'd12);

        // 3x4x1, break at (2,1,0).
        walk(1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 2'd1, 2'd0, 1, 1'b0, "b_brk");
        check("b_brk_lit_result", 64'(b_result), 64'd1023);
        check("b_brk_lit_count", 64'(b_count), 64'd10);
        last_a = (b_addrs.size() > 0) ? b_addrs[b_addrs.size() - 1] : -1;
        check("b_brk_last_addr", 64'(last_a), 64'd9);

        // Randomized walks on both instances.
        for (int t = 0; t < 10; t++) begin
            w  = 1'($urandom);
            jr = 1'($urandom);
            mr = 1'($urandom);
            br = 1'($urandom);
            rd = $urandom_range(1, 4);
            for (int a = 0; a < 24; a++) mem[a] = 8'($urandom);
            if (w) begin
                ri = 2'($urandom_range(0, 3));
                rj = 2'($urandom_range(0, 3));
                rk = 2'($urandom_range(0, 1));
            end else begin
                ri = 2'($urandom_range(0, 1));
                rj = 2'($urandom_range(0, 3));
                rk = 2'($urandom_range(0, 3));
            end
            walk(w, jr, mr, br, ri, rj, rk, rd, (rd >= 3) && 1'($urandom),
                 $sformatf("rnd%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/foreach_walk_ctrl.md
FOREACH_WALK_CTRL -- requirements
Module: foreach_walk_ctrl

Interface
REQ-001 SHALL have parameter D0, default 2, extent of outer index i.
REQ-002 SHALL have parameter D1, default 3, extent of middle index j.
REQ-003 SHALL have parameter D2, default 4, extent of inner index k.
REQ-004 SHALL have parameter DW, default 8, element width.
REQ-005 SHALL have parameter ACC_W, default 32, accumulator/result width.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port start, input, 1, begin a walk when idle.
REQ-009 SHALL have port j_desc, input, 1, iterate j from D1-1 down to 0.
REQ-010 SHALL have port mode, input, 1, 0 = plain sum, 1 = shift-add.
REQ-011 SHALL have port brk_en, input, 1, enable early break.
REQ-012 SHALL have ports brk_i/brk_j/brk_k, inputs, clog2 of D0/D1/D2 (min 1), break index.
REQ-013 SHALL have port rd_req, output, 1, element read request.
REQ-014 SHALL have port rd_addr, output, clog2(D0*D1*D2), flat address i*D1*D2 + j*D2 + k.
REQ-015 SHALL have port rd_valid, input, 1, read data valid.
REQ-016 SHALL have port rd_data, input, DW, element value.
REQ-017 SHALL have port busy, output, 1, walk in progress.
REQ-018 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-019 SHALL have port result, output, ACC_W, final accumulator.
REQ-020 SHALL have port count, output, clog2(D0*D1*D2+1), elements accumulated.

Function
REQ-021 SHALL implement states IDLE, REQ, WAIT, DONE.
REQ-022 IDLE: start=1 SHALL latch j_desc, mode, brk_*; clear accumulator and count; set i=0, k=0, j=0 (or D1-1 if j_desc); go REQ.
REQ-023 REQ: SHALL assert rd_req for exactly one cycle with rd_addr of current (i,j,k), then go WAIT.
REQ-024 WAIT: SHALL hold rd_addr; rd_valid=1 SHALL accumulate rd_data (zero-extended) and increment count; unbounded wait permitted.
REQ-025 mode 0 SHALL compute acc = acc + data; mode 1 SHALL compute acc = (acc << 1) + data; both truncated modulo 2^ACC_W.
REQ-026 Index order SHALL be k innermost, then j, then i; k wraps D2-1 to 0 with j step; j wraps at its end (D1-1 ascending, 0 descending) with i increment.
REQ-027 After accumulating the last element, or the element equal to (brk_i,brk_j,brk_k) when brk_en, SHALL go DONE; otherwise REQ.
REQ-028 DONE: SHALL pulse done one cycle, load result, return to IDLE; result SHALL hold until next DONE.
REQ-029 busy SHALL be 1 in REQ, WAIT, DONE; 0 in IDLE.
REQ-030 start while busy SHALL be ignored; rd_valid outside WAIT SHALL be ignored.
REQ-031 Break index out of range SHALL be inert (full walk).
REQ-032 rd_data and config inputs changing mid-walk SHALL not affect latched config.

Reset
REQ-033 rst SHALL force IDLE immediately, aborting any walk; rd_req, busy, done, result, count, rd_addr SHALL be 0.
REQ-034 After deassertion, first start SHALL behave as REQ-022.

Structure
REQ-035 State enum and mode encoding SHALL live in shared package foreach_walk_pkg.
REQ-036 Index stepping SHALL be one sub-module foreach_idx_step (current i,j,k, j_desc -> next i,j,k, last flag); the rest stays in foreach_walk_ctrl.

Verification
REQ-037 Defaults, mode 0, data = 1 only at (1,2,3), 0 else, rd_valid next cycle -> result 1, count 24, done once.
REQ-038 D0=3, D1=4, D2=1, mode 1, all data 1 -> result 4095, count 12.
REQ-039 D0=3, D1=4, D2=1, brk_en, break (2,1,0), mode 1, all 1 -> count 10, result 1023, last rd_addr 9.
REQ-040 j_desc=1, defaults -> rd_addr sequence 8,9,10,11,4,5,6,7,0,1,2,3,20,...,15.
REQ-041 rd_valid delayed 5 cycles per element, start pulsed while busy -> single walk, count 24.
REQ-042 rst asserted in WAIT mid-walk -> busy, rd_req, count, result 0 same cycle; next start completes a full walk normally.
